// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: fetch FSM encoding, instruction
// field positions and the default reset PC.
package mips_pkg;

    typedef enum logic {
        S_FETCH = 1'b0,
        S_EXEC  = 1'b1
    } state_t;

    localparam int unsigned OP_MSB     = 31;
    localparam int unsigned OP_LSB     = 26;
    localparam int unsigned FUNCT_MSB  = 5;
    localparam int unsigned FUNCT_LSB  = 0;
    localparam int unsigned IMM_MSB    = 15;
    localparam int unsigned IMM_LSB    = 0;
    localparam int unsigned TARGET_MSB = 25;
    localparam int unsigned TARGET_LSB = 0;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Word-align an address by clearing the byte offset.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_if.sv
// Instruction memory request/acknowledge bus between ifetch and memory.
interface ifetch_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/ifetch_pc_next.sv
// Next-PC selection: sequential, PC-relative branch or pseudo-direct jump.
module pc_next
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [25:0] instr_lo,
    input  logic        pcsrc,
    input  logic        jump,
    output logic [31:0] pcplus4,
    output logic [31:0] next_pc
);

    logic [31:0] branch_off;
    logic [31:0] branch_target;
    logic [31:0] jump_target;

    // Compute all candidate targets, jump takes priority over branch.
    always_comb begin
        pcplus4       = pc + 32'd4;
        branch_off    = {{14{instr_lo[IMM_MSB]}}, instr_lo[IMM_MSB:IMM_LSB], 2'b00};
        branch_target = pcplus4 + branch_off;
        jump_target   = {pcplus4[31:28], instr_lo[TARGET_MSB:TARGET_LSB], 2'b00};
        if (jump) begin
            next_pc = jump_target;
        end else if (pcsrc) begin
            next_pc = branch_target;
        end else begin
            next_pc = pcplus4;
        end
    end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch unit: owns PC, instruction register and retire counter,
// fetches over a req/ack bus and advances the PC once EXEC completes.
module ifetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    ifetch_if.master    imem,
    input  logic        pcsrc,
    input  logic        jump,
    input  logic        stall,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pcplus4,
    output logic [31:0] retired
);

    localparam logic [31:0] RESET_PC_ALIGNED = word_align(RESET_PC);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] retired_q, retired_d;
    logic [31:0] next_pc;
    logic        imem_req;

    pc_next u_pc_next (
        .pc       (pc_q),
        .instr_lo (instr_q[25:0]),
        .pcsrc    (pcsrc),
        .jump     (jump),
        .pcplus4  (pcplus4),
        .next_pc  (next_pc)
    );

    // State, PC, instruction and retire registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC_ALIGNED;
            instr_q   <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
        end
    end

    // Next-state logic and handshake outputs; outputs are quiet during reset.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        retired_d   = retired_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                imem_req = !reset;
                if (imem.imem_ack) begin
                    instr_d = imem.imem_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                instr_valid = !reset;
                if (!stall) begin
                    pc_d      = next_pc;
                    retired_d = retired_q + 32'd1;
                    state_d   = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign imem.imem_req  = imem_req;
    assign imem.imem_addr = pc_q;
    assign instr          = instr_q;
    assign op             = instr_q[OP_MSB:OP_LSB];
    assign funct          = instr_q[FUNCT_MSB:FUNCT_LSB];
    assign pc             = pc_q;
    assign retired        = retired_q;

endmodule

// File: tb/tb_ifetch.sv
module tb_ifetch;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ifetch_if imem ();
    ifetch_if imem2 ();

    logic        pcsrc, jump, stall;
    logic [31:0] instr, pc, pcplus4, retired;
    logic [5:0]  op, funct;
    logic        instr_valid;

    logic        pcsrc2, jump2, stall2;
    logic [31:0] instr2, pc2, pcplus4_2, retired2;
    logic [5:0]  op2, funct2;
    logic        instr_valid2;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [31:0] exp_retired;

    ifetch #(.RESET_PC(32'h0040_0003)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .imem        (imem),
        .pcsrc       (pcsrc),
        .jump        (jump),
        .stall       (stall),
        .instr       (instr),
        .op          (op),
        .funct       (funct),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pcplus4     (pcplus4),
        .retired     (retired)
    );

    ifetch #(.RESET_PC(32'hA000_0010)) u_dut2 (
        .clk         (clk),
        .reset       (reset),
        .imem        (imem2),
        .pcsrc       (pcsrc2),
        .jump        (jump2),
        .stall       (stall2),
        .instr       (instr2),
        .op          (op2),
        .funct       (funct2),
        .instr_valid (instr_valid2),
        .pc          (pc2),
        .pcplus4     (pcplus4_2),
        .retired     (retired2)
    );

    // Reference next-PC rule written directly from the ISA description.
    function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] w,
                                               input logic ps, input logic js);
        logic [31:0] seq;
        int          off;
        seq = p + 32'd4;
        off = int'($signed(w[15:0])) * 4;
        if (js) return {seq[31:28], w[25:0], 2'b00};
        if (ps) return seq + 32'(off);
        return seq;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One zero-wait fetch followed by one unstalled EXEC; updates the model.
    task automatic fetch_exec(input logic [31:0] w, input logic ps, input logic js);
        imem.imem_ack   = 1'b1;
        imem.imem_rdata = w;
        tick();
        imem.imem_ack = 1'b0;
        pcsrc = ps;
        jump  = js;
        tick();
        pcsrc = 1'b0;
        jump  = 1'b0;
        exp_pc      = model_next(exp_pc, w, ps, js);
        exp_instr   = w;
        exp_retired = exp_retired + 32'd1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (imem.imem_req !== 1'b0) begin errors++;
            $display("FAIL reset_req: got %b want 0", imem.imem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++;
            $display("FAIL reset_valid: got %b want 0", instr_valid); end
        checks++; if (pc !== 32'h0040_0000) begin errors++;
            $display("FAIL reset_pc: got %h want 00400000", pc); end
        checks++; if ({instr, op, funct} !== 44'h0) begin errors++;
            $display("FAIL reset_instr: got %h/%h/%h want 0", instr, op, funct); end
        checks++; if (retired !== 32'h0) begin errors++;
            $display("FAIL reset_retired: got %h want 0", retired); end
        checks++; if (pcplus4 !== 32'h0040_0004) begin errors++;
            $display("FAIL reset_pcplus4: got %h want 00400004", pcplus4); end
        reset = 1'b0;
        #1;
        checks++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h0040_0000) begin
            errors++;
            $display("FAIL release_fetch: got req=%b addr=%h want 1/00400000",
                     imem.imem_req, imem.imem_addr); end
        exp_pc      = 32'h0040_0000;
        exp_instr   = 32'h0;
        exp_retired = 32'h0;
    endtask

    task automatic test_sequential();
        logic [31:0] w;
        imem.imem_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            w = $urandom;
            checks++; if (instr_valid !== 1'b0 || imem.imem_req !== 1'b1) begin errors++;
                $display("FAIL seq_fetch_phase: got valid=%b req=%b want 0/1",
                         instr_valid, imem.imem_req); end
            checks++; if (imem.imem_addr !== exp_pc) begin errors++;
                $display("FAIL seq_addr: got %h want %h", imem.imem_addr, exp_pc); end
            imem.imem_rdata = w;
            tick();
            checks++; if (instr_valid !== 1'b1 || imem.imem_req !== 1'b0) begin errors++;
                $display("FAIL seq_exec_phase: got valid=%b req=%b want 1/0",
                         instr_valid, imem.imem_req); end
            checks++; if (instr !== w || op !== w[31:26] || funct !== w[5:0]) begin errors++;
                $display("FAIL seq_instr: got %h want %h", instr, w); end
            checks++; if (pc !== exp_pc) begin errors++;
                $display("FAIL seq_pc: got %h want %h", pc, exp_pc); end
            tick();
            exp_pc      = exp_pc + 32'd4;
            exp_instr   = w;
            exp_retired = exp_retired + 32'd1;
            checks++; if (retired !== exp_retired) begin errors++;
                $display("FAIL seq_retired: got %0d want %0d", retired, exp_retired); end
        end
        imem.imem_ack = 1'b0;
        checks++; if (pc !== 32'h0040_0010) begin errors++;
            $display("FAIL seq_final_pc: got %h want 00400010", pc); end
    endtask

    task automatic test_ack_delay();
        logic [31:0] w;
        w = $urandom;
        imem.imem_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            imem.imem_rdata = $urandom;
            checks++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== exp_pc) begin errors++;
                $display("FAIL delay_req_%0d: got req=%b addr=%h want 1/%h",
                         k, imem.imem_req, imem.imem_addr, exp_pc); end
            checks++; if (instr_valid !== 1'b0 || instr !== exp_instr) begin errors++;
                $display("FAIL delay_hold_%0d: got valid=%b instr=%h want 0/%h",
                         k, instr_valid, instr, exp_instr); end
            tick();
        end
        checks++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== exp_pc) begin errors++;
            $display("FAIL delay_req_ack: got req=%b addr=%h want 1/%h",
                     imem.imem_req, imem.imem_addr, exp_pc); end
        imem.imem_ack   = 1'b1;
        imem.imem_rdata = w;
        tick();
        imem.imem_ack = 1'b0;
        checks++; if (instr_valid !== 1'b1 || instr !== w) begin errors++;
            $display("FAIL delay_capture: got valid=%b instr=%h want 1/%h",
                     instr_valid, instr, w); end
        tick();
        exp_pc      = exp_pc + 32'd4;
        exp_instr   = w;
        exp_retired = exp_retired + 32'd1;
    endtask

    task automatic test_branch();
        fetch_exec(32'h0800_0040, 1'b0, 1'b1);
        checks++; if (pc !== 32'h0000_0100) begin errors++;
            $display("FAIL branch_setup_pc: got %h want 00000100", pc); end
        fetch_exec(32'h1000_FFFE, 1'b1, 1'b0);
        checks++; if (pc !== 32'h0000_00FC) begin errors++;
            $display("FAIL branch_taken_pc: got %h want 000000fc", pc); end
        fetch_exec(32'h0800_0040, 1'b0, 1'b1);
        fetch_exec(32'h1000_FFFE, 1'b0, 1'b0);
        checks++; if (pc !== 32'h0000_0104 || pcplus4 !== 32'h0000_0108) begin errors++;
            $display("FAIL branch_not_taken: got pc=%h pcplus4=%h want 00000104/00000108",
                     pc, pcplus4); end
        checks++; if (retired !== exp_retired) begin errors++;
            $display("FAIL branch_retired: got %0d want %0d", retired, exp_retired); end
    endtask

    task automatic test_stall();
        logic [31:0] w;
        w = $urandom;
        imem.imem_ack   = 1'b1;
        imem.imem_rdata = w;
        tick();
        stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            imem.imem_rdata = ~w;
            checks++; if (instr_valid !== 1'b1 || pc !== exp_pc || instr !== w) begin errors++;
                $display("FAIL stall_hold_%0d: got valid=%b pc=%h instr=%h want 1/%h/%h",
                         k, instr_valid, pc, instr, exp_pc, w); end
            checks++; if (retired !== exp_retired || imem.imem_req !== 1'b0) begin errors++;
                $display("FAIL stall_retired_%0d: got ret=%0d req=%b want %0d/0",
                         k, retired, imem.imem_req, exp_retired); end
            tick();
        end
        stall         = 1'b0;
        imem.imem_ack = 1'b0;
        tick();
        exp_pc      = exp_pc + 32'd4;
        exp_instr   = w;
        exp_retired = exp_retired + 32'd1;
        checks++; if (retired !== exp_retired || pc !== exp_pc || imem.imem_req !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: got ret=%0d pc=%h req=%b want %0d/%h/1",
                     retired, pc, imem.imem_req, exp_retired, exp_pc); end
    endtask

    task automatic test_jump();
        checks++; if (imem2.imem_req !== 1'b1 || imem2.imem_addr !== 32'hA000_0010) begin
            errors++;
            $display("FAIL jump_fetch: got req=%b addr=%h want 1/a0000010",
                     imem2.imem_req, imem2.imem_addr); end
        imem2.imem_ack   = 1'b1;
        imem2.imem_rdata = 32'h0800_0040;
        tick();
        imem2.imem_ack = 1'b0;
        jump2  = 1'b1;
        pcsrc2 = 1'b1;
        checks++; if (instr_valid2 !== 1'b1 || op2 !== 6'd2) begin errors++;
            $display("FAIL jump_exec: got valid=%b op=%h want 1/02", instr_valid2, op2); end
        tick();
        jump2  = 1'b0;
        pcsrc2 = 1'b0;
        checks++; if (pc2 !== 32'hA000_0100 || retired2 !== 32'd1) begin errors++;
            $display("FAIL jump_target: got pc=%h ret=%0d want a0000100/1", pc2, retired2); end
    endtask

    task automatic test_random();
        logic [31:0] w;
        logic        ps, js;
        int          nwait, nstall;
        for (int n = 0; n < 40; n++) begin
            w      = $urandom;
            ps     = 1'($urandom);
            js     = 1'($urandom_range(0, 3) == 0);
            nwait  = $urandom_range(0, 3);
            nstall = $urandom_range(0, 2);
            checks++; if (retired !== exp_retired) begin errors++;
                $display("FAIL rnd_retired_%0d: got %0d want %0d", n, retired, exp_retired); end
            for (int k = 0; k < nwait; k++) begin
                imem.imem_ack   = 1'b0;
                imem.imem_rdata = $urandom;
                pcsrc = 1'($urandom);
                jump  = 1'($urandom);
                checks++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== exp_pc ||
                              instr_valid !== 1'b0) begin errors++;
                    $display("FAIL rnd_wait_%0d: got req=%b addr=%h valid=%b want 1/%h/0",
                             n, imem.imem_req, imem.imem_addr, instr_valid, exp_pc); end
                tick();
            end
            checks++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== exp_pc) begin errors++;
                $display("FAIL rnd_addr_%0d: got req=%b addr=%h want 1/%h",
                         n, imem.imem_req, imem.imem_addr, exp_pc); end
            imem.imem_ack   = 1'b1;
            imem.imem_rdata = w;
            tick();
            checks++; if (instr_valid !== 1'b1 || instr !== w || op !== w[31:26] ||
                          funct !== w[5:0] || pc !== exp_pc ||
                          pcplus4 !== exp_pc + 32'd4) begin errors++;
                $display("FAIL rnd_exec_%0d: got valid=%b instr=%h pc=%h want 1/%h/%h",
                         n, instr_valid, instr, pc, w, exp_pc); end
            for (int k = 0; k < nstall; k++) begin
                stall           = 1'b1;
                imem.imem_ack   = 1'b1;
                imem.imem_rdata = ~w;
                tick();
                checks++; if (instr_valid !== 1'b1 || instr !== w || pc !== exp_pc) begin
                    errors++;
                    $display("FAIL rnd_stall_%0d: got valid=%b instr=%h pc=%h want 1/%h/%h",
                             n, instr_valid, instr, pc, w, exp_pc); end
            end
            stall         = 1'b0;
            imem.imem_ack = 1'b0;
            pcsrc         = ps;
            jump          = js;
            tick();
            pcsrc       = 1'b0;
            jump        = 1'b0;
            exp_pc      = model_next(exp_pc, w, ps, js);
            exp_instr   = w;
            exp_retired = exp_retired + 32'd1;
            checks++; if (pc !== exp_pc) begin errors++;
                $display("FAIL rnd_next_pc_%0d: got %h want %h (ps=%b js=%b)",
                         n, pc, exp_pc, ps, js); end
        end
    endtask

    task automatic test_reset_mid();
        // Reset during a FETCH wait cycle.
        imem.imem_ack = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        checks++; if (imem.imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h0040_0000 ||
                      instr !== 32'h0 || retired !== 32'h0) begin errors++;
            $display("FAIL rst_fetch: got req=%b valid=%b pc=%h instr=%h ret=%0d want reset",
                     imem.imem_req, instr_valid, pc, instr, retired); end
        reset = 1'b0;
        #1;
        checks++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h0040_0000) begin
            errors++;
            $display("FAIL rst_fetch_restart: got req=%b addr=%h want 1/00400000",
                     imem.imem_req, imem.imem_addr); end
        // Reset during an EXEC stall cycle: the held instruction must not retire.
        imem.imem_ack   = 1'b1;
        imem.imem_rdata = 32'h1234_5678;
        tick();
        imem.imem_ack = 1'b0;
        stall         = 1'b1;
        tick();
        checks++; if (instr_valid !== 1'b1 || retired !== 32'h0) begin errors++;
            $display("FAIL rst_exec_pre: got valid=%b ret=%0d want 1/0", instr_valid, retired); end
        reset = 1'b1;
        tick();
        stall = 1'b0;
        checks++; if (instr_valid !== 1'b0 || imem.imem_req !== 1'b0 || pc !== 32'h0040_0000 ||
                      {instr, op, funct} !== 44'h0 || retired !== 32'h0) begin errors++;
            $display("FAIL rst_exec: got valid=%b req=%b pc=%h instr=%h ret=%0d want reset",
                     instr_valid, imem.imem_req, pc, instr, retired); end
        tick();
        reset = 1'b0;
        #1;
        checks++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h0040_0000 ||
                      retired !== 32'h0) begin errors++;
            $display("FAIL rst_exec_restart: got req=%b addr=%h ret=%0d want 1/00400000/0",
                     imem.imem_req, imem.imem_addr, retired); end
    endtask

    initial begin
        reset            = 1'b1;
        pcsrc            = 1'b0;
        jump             = 1'b0;
        stall            = 1'b0;
        imem.imem_ack    = 1'b0;
        imem.imem_rdata  = 32'h0;
        pcsrc2           = 1'b0;
        jump2            = 1'b0;
        stall2           = 1'b0;
        imem2.imem_ack   = 1'b0;
        imem2.imem_rdata = 32'h0;
        test_reset();
        test_sequential();
        test_ack_delay();
        test_branch();
        test_stall();
        test_jump();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
